// File: rtl/fifo_uart_tx.sv
// Drains a FIFO with registered read data and serialises each byte as a UART frame:
// start bit, data LSB first, optional even parity, one stop bit.
module fifo_uart_tx #(
    parameter int data_width   = 8,
    parameter int clks_per_bit = 16,
    parameter int parity_en    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [data_width-1:0] data_in,
    output logic                  read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int BAUD_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int BIT_W  = (data_width > 1) ? $clog2(data_width) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clks_per_bit - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(data_width - 1);

    // IDLE wait | REQ pop | LATCH capture FIFO data | START, DATA, PARITY, STOP serial bits
    typedef enum logic [2:0] {IDLE, REQ, LATCH, START, DATA, PARITY, STOP} state_t;

    state_t                  state, next_state;
    logic [BAUD_W-1:0]       baud_cnt, baud_d;
    logic [BIT_W-1:0]        bit_cnt, bit_d;
    logic [data_width-1:0]   shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    tx_d;
    logic                    baud_last;

    always_comb begin
        next_state = state;
        baud_d     = baud_cnt;
        bit_d      = bit_cnt;
        shift_d    = shift_q;
        par_d      = par_q;
        baud_last  = (baud_cnt == BAUD_LAST);
        case (state)
            IDLE: begin
                if (enable && !empty) next_state = REQ;
            end
            REQ: next_state = LATCH;
            LATCH: begin
                shift_d    = data_in;
                par_d      = ^data_in;
                baud_d     = '0;
                bit_d      = '0;
                next_state = START;
            end
            START: begin
                if (baud_last) begin
                    baud_d     = '0;
                    next_state = DATA;
                end else begin
                    baud_d = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_d      = '0;
                        next_state = (parity_en != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_cnt + BAUD_W'(1);
                end
            end
            PARITY: begin
                if (baud_last) begin
                    baud_d     = '0;
                    next_state = STOP;
                end else begin
                    baud_d = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d     = '0;
                    next_state = (enable && !empty) ? REQ : IDLE;
                end else begin
                    baud_d = baud_cnt + BAUD_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // tx is registered, so its level is derived from where the FSM is heading
    always_comb begin
        tx_d = 1'b1;
        case (next_state)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx       <= 1'b1;
            read_en  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= next_state;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx       <= tx_d;
            read_en  <= (next_state == REQ);
            busy     <= (next_state != IDLE);
        end
    end

    assign frame_done = (state == STOP) && baud_last;

endmodule
